// File: rtl/fifo_write_arbiter_if.sv
// Producer handshake and fifo write-side bundle shared by the arbiter and its environment.
// The master modport is the arbiter's view; slave is the producers/fifo side.
interface fifo_write_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32
);
    logic [NUM_PORTS-1:0]       req;
    logic [NUM_PORTS*WIDTH-1:0] data_in;
    logic [NUM_PORTS-1:0]       ready;
    logic [NUM_PORTS-1:0]       grant;
    logic                       fifo_full;
    logic                       fifo_we;
    logic [WIDTH-1:0]           fifo_data;

    modport master (
        input  req, data_in, fifo_full,
        output ready, grant, fifo_we, fifo_data
    );

    modport slave (
        output req, data_in, fifo_full,
        input  ready, grant, fifo_we, fifo_data
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one fifo write port among NUM_PORTS producers.
//   state | meaning
//   IDLE  | no owner; pick next requester starting at rr_ptr
//   GRANT | owner streams up to BURST_LEN words; stalls while fifo_full
module fifo_write_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_BITS  = 2,
    parameter int WIDTH      = 32,
    parameter int BURST_LEN  = 8,
    parameter int COUNT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    fifo_write_arbiter_if.master  bus,
    output logic                  busy,
    output logic [COUNT_BITS-1:0] words_written
);
    localparam int BEAT_BITS = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BURST_LEN - 1);
    localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(NUM_PORTS - 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                 state, state_n;
    logic [PORT_BITS-1:0]   owner, owner_n;
    logic [PORT_BITS-1:0]   rr_ptr, rr_ptr_n;
    logic [BEAT_BITS-1:0]   beat_cnt, beat_n;
    logic [NUM_PORTS-1:0]   grant, grant_n;
    logic                   fifo_we, we_n;
    logic [WIDTH-1:0]       fifo_data, data_n;
    logic [COUNT_BITS-1:0]  ww_n;
    logic [NUM_PORTS-1:0]   ready_c;

    logic                   found;
    logic [PORT_BITS-1:0]   pick;
    logic [PORT_BITS-1:0]   cand;
    int                     tmp;
    logic                   xfer;
    logic [WIDTH-1:0]       owner_word;

    // Rotating priority scan; wrap is explicit so non-power-of-two port counts work.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        tmp   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            tmp = int'(rr_ptr) + i;
            if (tmp >= NUM_PORTS) tmp = tmp - NUM_PORTS;
            cand = PORT_BITS'(tmp);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign owner_word = bus.data_in[int'(owner)*WIDTH +: WIDTH];
    assign xfer       = (state == GRANT) && bus.req[owner] && !bus.fifo_full;

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_ptr_n = rr_ptr;
        beat_n   = beat_cnt;
        grant_n  = grant;
        we_n     = xfer;
        data_n   = xfer ? owner_word : fifo_data;
        ww_n     = words_written + COUNT_BITS'(xfer);
        ready_c  = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = GRANT;
                    owner_n       = pick;
                    beat_n        = '0;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                end
            end
            GRANT: begin
                ready_c[owner] = !bus.fifo_full;
                if (xfer) beat_n = beat_cnt + 1'b1;
                // A stall (fifo_full) never ends a burst, even if req drops meanwhile.
                if ((xfer && beat_cnt == LAST_BEAT) || (!bus.req[owner] && !bus.fifo_full)) begin
                    state_n  = IDLE;
                    grant_n  = '0;
                    rr_ptr_n = (owner == LAST_PORT) ? '0 : owner + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            grant         <= '0;
            fifo_we       <= 1'b0;
            fifo_data     <= '0;
            words_written <= '0;
        end else begin
            state         <= state_n;
            owner         <= owner_n;
            rr_ptr        <= rr_ptr_n;
            beat_cnt      <= beat_n;
            grant         <= grant_n;
            fifo_we       <= we_n;
            fifo_data     <= data_n;
            words_written <= ww_n;
        end
    end

    assign bus.ready     = ready_c;
    assign bus.grant     = grant;
    assign bus.fifo_we   = fifo_we;
    assign bus.fifo_data = fifo_data;
    assign busy          = (state == GRANT);
endmodule
